// File: rtl/lpcu_pkg.sv
// Shared opcode/ALU encodings, control-word layout and FSM states for the
// low-power control unit.
package lpcu_pkg;

   localparam logic [2:0] OPC_NOP   = 3'b000;
   localparam logic [2:0] OPC_ADD   = 3'b001;
   localparam logic [2:0] OPC_SUB   = 3'b010;
   localparam logic [2:0] OPC_AND   = 3'b011;
   localparam logic [2:0] OPC_OR    = 3'b100;
   localparam logic [2:0] OPC_LOAD  = 3'b101;
   localparam logic [2:0] OPC_STORE = 3'b110;
   localparam logic [2:0] OPC_JUMP  = 3'b111;

   localparam logic [2:0] ALU_NONE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       branch;
      logic       jump;
   } ctrl_t;

   typedef enum logic {
      ACTIVE = 1'b0,
      SLEEP  = 1'b1
   } state_t;

endpackage

// File: rtl/lpcu_decoder.sv
// Purely combinational opcode to control-word mapping; every opcode value
// has an explicit entry so nothing unknown can leak into the datapath.
module lpcu_decoder
   import lpcu_pkg::*;
(
   input  logic [2:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         OPC_NOP: begin
            ctrl.alu_op = ALU_NONE;
         end
         OPC_ADD: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OPC_SUB: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SUB;
         end
         OPC_AND: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_AND;
         end
         OPC_OR: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OR;
         end
         // Loads and stores compute the address as base + immediate.
         OPC_LOAD: begin
            ctrl.reg_write = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OPC_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OPC_JUMP: begin
            ctrl.jump = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/low_power_ctrl_unit.sv
// Registered instruction decoder that holds its outputs while idle and drops
// into a cleared SLEEP state after IDLE_CYCLES consecutive idle cycles.
module low_power_ctrl_unit
   import lpcu_pkg::*;
#(
   parameter int IDLE_CYCLES = 8,
   parameter int IDLE_CNT_W  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       valid,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       alu_src,
   output logic [2:0] alu_op,
   output logic       branch,
   output logic       jump
);

   localparam logic [IDLE_CNT_W-1:0] IDLE_LIMIT = IDLE_CNT_W'(IDLE_CYCLES);

   state_t                state_q, state_d;
   ctrl_t                 ctrl_q, ctrl_d, dec_ctrl;
   logic [IDLE_CNT_W-1:0] idle_q, idle_d;
   logic                  load_en;

   lpcu_decoder u_decoder (
      .opcode (opcode),
      .ctrl   (dec_ctrl)
   );

   // The output register is only enabled on a valid instruction or on the
   // SLEEP-entry edge, so the control strobes stay quiet while idle.
   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      ctrl_d  = '0;
      load_en = 1'b0;
      if (valid) begin
         state_d = ACTIVE;
         idle_d  = '0;
         ctrl_d  = dec_ctrl;
         load_en = 1'b1;
      end else if (state_q == ACTIVE) begin
         if (idle_q != IDLE_LIMIT)
            idle_d = idle_q + 1'b1;
         if (idle_d == IDLE_LIMIT) begin
            state_d = SLEEP;
            load_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACTIVE;
         idle_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         if (load_en)
            ctrl_q <= ctrl_d;
      end
   end

   assign reg_write = ctrl_q.reg_write;
   assign mem_read  = ctrl_q.mem_read;
   assign mem_write = ctrl_q.mem_write;
   assign alu_src   = ctrl_q.alu_src;
   assign alu_op    = ctrl_q.alu_op;
   assign branch    = ctrl_q.branch;
   assign jump      = ctrl_q.jump;

endmodule

// File: tb/tb_low_power_ctrl_unit.sv
// Directed self-checking bench for low_power_ctrl_unit with hand-computed
// control words {reg_write, mem_read, mem_write, alu_src, alu_op, branch, jump}.
module tb_low_power_ctrl_unit;

   localparam int IDLE = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       valid;
   logic       reg_write, mem_read, mem_write, alu_src, branch, jump;
   logic [2:0] alu_op;
   logic [8:0] outs;

   int test_count = 0;
   int fail_count = 0;

   logic [8:0] exp_tab [8];

   low_power_ctrl_unit #(
      .IDLE_CYCLES (IDLE),
      .IDLE_CNT_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .valid     (valid),
      .reg_write (reg_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .alu_src   (alu_src),
      .alu_op    (alu_op),
      .branch    (branch),
      .jump      (jump)
   );

   assign outs = {reg_write, mem_read, mem_write, alu_src, alu_op, branch, jump};

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive at the falling edge, then advance just past the next rising edge.
   task automatic applyStimulus(input logic v, input logic [2:0] opc);
      @(negedge clk);
      valid  = v;
      opcode = opc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_tab[0] = 9'b0000_000_0_0;
      exp_tab[1] = 9'b1000_001_0_0;
      exp_tab[2] = 9'b1000_010_0_0;
      exp_tab[3] = 9'b1000_011_0_0;
      exp_tab[4] = 9'b1000_100_0_0;
      exp_tab[5] = 9'b1101_001_0_0;
      exp_tab[6] = 9'b0011_001_0_0;
      exp_tab[7] = 9'b0000_000_0_1;

      rst    = 1'b1;
      valid  = 1'b0;
      opcode = 3'b001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_zero", outs, 9'b0);
      rst = 1'b0;

      // NOP, ADD, SUB each held for two cycles, one cycle of latency
      applyStimulus(1'b1, 3'd0);
      checkOutput("nop_1", outs, exp_tab[0]);
      applyStimulus(1'b1, 3'd0);
      checkOutput("nop_2", outs, exp_tab[0]);
      @(negedge clk);
      valid  = 1'b1;
      opcode = 3'd1;
      #1;
      checkOutput("add_latency", outs, exp_tab[0]);
      @(posedge clk);
      #1;
      checkOutput("add_1", outs, exp_tab[1]);
      applyStimulus(1'b1, 3'd1);
      checkOutput("add_2", outs, exp_tab[1]);
      applyStimulus(1'b1, 3'd2);
      checkOutput("sub_1", outs, exp_tab[2]);
      applyStimulus(1'b1, 3'd2);
      checkOutput("sub_2", outs, exp_tab[2]);

      // Full decode-table sweep
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3'(i));
         checkOutput($sformatf("sweep_opc%0d", i), outs, exp_tab[i]);
      end

      // Idle hold: opcode noise while valid=0 must not change outputs
      applyStimulus(1'b1, 3'd1);
      checkOutput("idle_pre_add", outs, exp_tab[1]);
      for (int i = 0; i < IDLE - 1; i++) begin
         applyStimulus(1'b0, 3'($urandom_range(7)));
         checkOutput($sformatf("idle_hold_%0d", i), outs, exp_tab[1]);
      end
      applyStimulus(1'b0, 3'($urandom_range(7)));
      checkOutput("sleep_enter", outs, 9'b0);
      applyStimulus(1'b0, 3'd5);
      checkOutput("sleep_stay", outs, 9'b0);

      // Wake with OR; idle counter must restart from zero
      applyStimulus(1'b1, 3'd4);
      checkOutput("wake_or", outs, exp_tab[4]);
      for (int i = 0; i < IDLE - 1; i++) begin
         applyStimulus(1'b0, 3'd7);
         checkOutput($sformatf("rewake_hold_%0d", i), outs, exp_tab[4]);
      end
      applyStimulus(1'b0, 3'd7);
      checkOutput("resleep", outs, 9'b0);
      applyStimulus(1'b1, 3'd5);
      checkOutput("wake_load", outs, exp_tab[5]);

      // Partial idle run then valid: counter must clear
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 3'd0);
      applyStimulus(1'b1, 3'd3);
      checkOutput("and_after_idle", outs, exp_tab[3]);
      for (int i = 0; i < IDLE - 1; i++)
         applyStimulus(1'b0, 3'd0);
      checkOutput("and_still_held", outs, exp_tab[3]);

      // Back-to-back SUB / STORE
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 3'd2 : 3'd6);
         checkOutput($sformatf("b2b_%0d", i), outs, (i % 2 == 0) ? exp_tab[2] : exp_tab[6]);
      end

      // Asynchronous reset mid-stream clears before the next edge
      rst = 1'b1;
      #1;
      checkOutput("async_reset", outs, 9'b0);
      @(negedge clk);
      valid = 1'b0;
      rst   = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_reset_idle", outs, 9'b0);
      applyStimulus(1'b1, 3'd1);
      checkOutput("post_reset_add", outs, exp_tab[1]);
      applyStimulus(1'b1, 3'd7);
      checkOutput("post_reset_jump", outs, exp_tab[7]);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/low_power_ctrl_unit.md
Name: low_power_ctrl_unit

Overview:
Registered instruction decoder for the small 3-bit-opcode core. It sits between fetch and the datapath and turns a valid opcode into datapath control strobes. It saves power in two ways: the output register loads only on valid instructions, so outputs do not toggle while the core is idle, and it moves to a cleared SLEEP state after a run of idle cycles.

Parameters:
IDLE_CYCLES, 8, number of consecutive valid=0 cycles before entering SLEEP (range 1..255).
IDLE_CNT_W, 8, width of the internal idle counter; must satisfy 2^IDLE_CNT_W > IDLE_CYCLES.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
opcode  in  3  instruction opcode; sampled only when valid=1.
valid  in  1  opcode qualifier.
reg_write  out  1  register-file write enable.
mem_read  out  1  data-memory read enable.
mem_write  out  1  data-memory write enable.
alu_src  out  1  1 selects the immediate as ALU operand B.
alu_op  out  3  ALU operation: 000 none, 001 add, 010 sub, 011 and, 100 or.
branch  out  1  branch strobe; reserved and driven 0 by this revision.
jump  out  1  jump strobe.

Behaviour:
- All outputs are registered; outputs are never combinational from the inputs.
- Reset (rst=1, asynchronous): every output is 0 (alu_op=000), state=ACTIVE, idle counter=0.
- Decode table (reg_write, mem_read, mem_write, alu_src, alu_op, branch, jump):
  - 000 NOP: 0, 0, 0, 0, 000, 0, 0
  - 001 ADD: 1, 0, 0, 0, 001, 0, 0
  - 010 SUB: 1, 0, 0, 0, 010, 0, 0
  - 011 AND: 1, 0, 0, 0, 011, 0, 0
  - 100 OR: 1, 0, 0, 0, 100, 0, 0
  - 101 LOAD: 1, 1, 0, 1, 001, 0, 0
  - 110 STORE: 0, 0, 1, 1, 001, 0, 0
  - 111 JUMP: 0, 0, 0, 0, 000, 0, 1
- Latency: opcode sampled with valid=1 at edge N appears on the outputs after edge N. A held opcode with valid=1 holds the outputs steady.
- Load enable: the output register is written only when valid=1, or on SLEEP entry.
- valid=0 in ACTIVE: outputs hold their last value; the idle counter increments, saturating at IDLE_CYCLES. Opcode changes while valid=0 have no effect.
- States:
  - ACTIVE: normal decode.
  - SLEEP: outputs cleared to all-zero; the idle counter is frozen.
- ACTIVE to SLEEP: at the edge where the idle counter reaches IDLE_CYCLES while valid=0. The outputs clear to 0 at that same edge.
- SLEEP to ACTIVE: on any edge with valid=1. That opcode is decoded at the same edge, so there is no wake penalty beyond the normal 1-cycle latency.
- Any valid=1 edge clears the idle counter to 0.
- Reset asserted mid-operation: outputs clear immediately (asynchronously); decoding resumes on the first valid=1 edge after reset release.
- No X propagation: every 3-bit opcode value is decoded, with no default-case holes.

Decomposition:
- Package lpcu_pkg holds:
  - opcode localparams (OPC_NOP..OPC_JUMP);
  - alu_op localparams (ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR);
  - a packed struct ctrl_t of the seven control fields;
  - a state enum {ACTIVE, SLEEP}.
- One sub-module, lpcu_decoder: purely combinational opcode to ctrl_t mapping.
- The top module holds the output register, idle counter and state machine.

Test Plan:
1. Reset: rst=1 for 2 cycles with valid=0 -> all outputs 0, alu_op=000; with rst=1 mid-stream, outputs go to 0 before the next clk edge.
2. Release reset, valid=1 with NOP, ADD, SUB each held 2 cycles -> (reg_write, alu_op) = (0, 000), then (1, 001), then (1, 010), each one cycle after the opcode is presented.
3. Sweep all 8 opcodes with valid=1 -> registered outputs match the decode table. LOAD gives reg_write=1, mem_read=1, alu_src=1, alu_op=001. STORE gives mem_write=1, alu_src=1. JUMP gives jump=1. branch is always 0.
4. After ADD, drop valid and toggle opcode randomly for IDLE_CYCLES-1 cycles -> outputs hold reg_write=1, alu_op=001 with zero toggles.
5. Keep valid=0 for IDLE_CYCLES cycles -> SLEEP entered and outputs cleared to 0. Then valid=1 with OR -> reg_write=1, alu_op=100 after one edge, and the idle counter restarts from 0.
6. Back-to-back valid instructions alternating SUB and STORE every cycle -> outputs update every cycle, with no dropped or stale decode.
